// File: rtl/dtc_share_arbiter.sv
// Round-robin time-share of one combinational classifier; accept -> EVAL -> RESP, response 2 cycles after accept.
// A stalled response (rsp_ready=0) closes the accept window, so no requester is granted until it drains.
module dtc_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int FEAT_W = 8,
  parameter int CLS_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ*FEAT_W-1:0]            req_feat,
  output logic [NREQ-1:0]                   req_ready,
  output logic [FEAT_W-1:0]                 cls_feat,
  input  logic [CLS_W-1:0]                  cls_class,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NREQ)-1:0]           rsp_id,
  output logic [CLS_W-1:0]                  rsp_class,
  input  logic                              clr_stats,
  output logic [(1<<CLS_W)*CNT_W-1:0]       stat_cnt,
  output logic                              busy
);

  localparam int ID_W = $clog2(NREQ);
  localparam int NCLS = 1 << CLS_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [FEAT_W-1:0] feat_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [CLS_W-1:0]  rsp_class_q;
  logic [CNT_W-1:0]  cnt_q [NCLS];

  logic              accept_win;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic              accept;

  // Reset gates the window so req_ready reads 0 while rst_n is low.
  assign accept_win = rst_n && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
  assign accept     = accept_win && gnt_any;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx_v;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_v   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[idx_v]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_v;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_q <= S_EVAL;
        S_EVAL:  state_q <= S_RESP;
        S_RESP:  if (rsp_ready) state_q <= accept ? S_EVAL : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      id_q   <= '0;
      feat_q <= '0;
    end else if (accept) begin
      ptr_q  <= ID_W'((int'(gnt_idx) + 1) % NREQ);
      id_q   <= gnt_idx;
      feat_q <= req_feat[gnt_idx*FEAT_W +: FEAT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q    <= '0;
      rsp_class_q <= '0;
    end else if (state_q == S_EVAL) begin
      rsp_id_q    <= id_q;
      rsp_class_q <= cls_class;
    end
  end

  // Clear takes priority over a same-cycle EVAL increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCLS; k++) cnt_q[k] <= '0;
    end else if (clr_stats) begin
      for (int k = 0; k < NCLS; k++) cnt_q[k] <= '0;
    end else if ((state_q == S_EVAL) && (cnt_q[cls_class] != {CNT_W{1'b1}})) begin
      cnt_q[cls_class] <= cnt_q[cls_class] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NCLS; k++) begin : g_stat
    assign stat_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign cls_feat  = feat_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_class = rsp_class_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dtc_share_arbiter.sv
// Directed + random bench for dtc_share_arbiter with a stub classifier (class = low feature bits).
module tb_dtc_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_feat;
  logic [3:0]  req_ready;
  logic [7:0]  cls_feat;
  logic [1:0]  cls_class;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_class;
  logic        clr_stats;
  logic [15:0] stat_cnt;
  logic        busy;

  assign cls_class = cls_feat[1:0];

  dtc_share_arbiter #(.NREQ(4), .FEAT_W(8), .CLS_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_feat(req_feat),
    .req_ready(req_ready), .cls_feat(cls_feat), .cls_class(cls_class),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_class(rsp_class), .clr_stats(clr_stats), .stat_cnt(stat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  // Transaction-level reference: a pending evaluation, an outstanding response, rotating priority.
  bit         m_eval, m_resp;
  int         m_ptr, m_id, m_rsp_id;
  logic [7:0] m_feat;
  logic [1:0] m_rsp_cls;
  int         m_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v == (4'b0001 << k)) return k;
    return -1;
  endfunction

  function automatic logic [15:0] model_stats();
    logic [15:0] p;
    for (int k = 0; k < 4; k++) p[k*4 +: 4] = m_cnt[k][3:0];
    return p;
  endfunction

  task automatic model_clear();
    m_eval = 0; m_resp = 0; m_ptr = 0; m_id = 0; m_rsp_id = 0;
    m_feat = '0; m_rsp_cls = '0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Checks every output against the model, then advances one clock.
  task automatic step();
    int         g;
    logic [3:0] exp_rdy;
    #2;
    g = (!m_eval && (!m_resp || rsp_ready)) ? model_grant(req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_eval || m_resp));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    chk("rsp_class", 32'(rsp_class), 32'(m_rsp_cls));
    chk("cls_feat", 32'(cls_feat), 32'(m_feat));
    chk("stat_cnt", 32'(stat_cnt), 32'(model_stats()));
    if (m_eval) begin
      m_rsp_cls = m_feat[1:0];
      m_rsp_id  = m_id;
      if (m_cnt[m_feat[1:0]] < 15) m_cnt[m_feat[1:0]]++;
      m_resp = 1;
      m_eval = 0;
    end else if (m_resp && rsp_ready) begin
      m_resp = 0;
    end
    if (clr_stats) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    if (g >= 0) begin
      m_feat = req_feat[g*8 +: 8];
      m_id   = g;
      m_ptr  = (g + 1) % 4;
      m_eval = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_class", 32'(rsp_class), 32'h0);
    chk("rst_cls_feat", 32'(cls_feat), 32'h0);
    chk("rst_stat_cnt", 32'(stat_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int gnt_q[$];
    int gnt_cyc[$];
    int nresp;
    rst_n = 1'b0; req_valid = '0; req_feat = '0; rsp_ready = 1'b1; clr_stats = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Single request from requester 2
    req_valid = 4'b0100;
    req_feat  = 32'h005A0000;
    #1 chk("single_rdy", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    #1 chk("single_rdy_once", 32'(req_ready), 32'h0);
    step();
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    chk("single_rsp_class", 32'(rsp_class), 32'h2);
    chk("single_stat2", 32'(stat_cnt[11:8]), 32'h1);
    step();
    step();

    // Full contention from ptr=0
    do_reset();
    req_valid = 4'b1111;
    req_feat  = 32'h03020100;
    nresp = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready != '0) begin
        gnt_q.push_back(onehot_idx(req_ready));
        gnt_cyc.push_back(c);
      end
      if (rsp_valid) begin
        chk("cont_rsp_id", 32'(rsp_id), 32'(nresp % 4));
        chk("cont_rsp_class", 32'(rsp_class), 32'(nresp % 4));
        nresp++;
        if (nresp == 4) chk("cont_stats", 32'(stat_cnt), 32'h1111);
      end
      step();
    end
    chk("cont_ngrants", 32'(gnt_q.size()), 32'd5);
    for (int i = 0; i < gnt_q.size() && i < 5; i++) begin
      chk("cont_order", 32'(gnt_q[i]), 32'(i % 4));
      chk("cont_spacing", 32'(gnt_cyc[i]), 32'(2 * i));
    end
    req_valid = '0;
    step();
    step();

    // Backpressure: ptr=1, requester 0 served while requester 3 waits
    req_valid = 4'b0001;
    req_feat  = 32'h44332211;
    step();
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id", 32'(rsp_id), 32'h0);
      chk("bp_rsp_class", 32'(rsp_class), 32'h1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    #1 chk("bp_eval_after", 32'(rsp_valid), 32'h0);
    step();
    step();

    // Saturation of a 4-bit counter, then clear against an EVAL increment
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    req_feat  = 32'hFFFFFFFF;
    for (int c = 0; c < 40; c++) begin
      req_valid = 4'($urandom_range(1, 15));
      step();
    end
    req_valid = '0;
    #1 chk("sat_stat3", 32'(stat_cnt[15:12]), 32'hF);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    #1 chk("clr_vs_eval", 32'(stat_cnt), 32'h0);
    step();

    // Reset during EVAL with requesters pending
    req_valid = 4'b0100;
    req_feat  = 32'h00C30000;
    step();
    req_valid = 4'b0011;
    do_reset();
    #1 chk("post_rst_grant", 32'(req_ready), 32'h1);
    step();

    // Withdrawal skip: ptr=1, requester 1 drops, requester 3 takes the slot
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    step();
    step();
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1 chk("skip_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b1111;
    step();
    #1 chk("skip_ptr_wrap", 32'(req_ready), 32'h1);
    step();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_feat  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/dtc_share_arbiter.md
# dtc_share_arbiter

Round-robin scheduler that lets NREQ independent requesters time-share one combinational decision-tree classifier (FEAT_W-bit feature vector in, CLS_W-bit class out). It accepts one feature vector at a time over a valid/ready handshake, registers it onto the classifier input, and captures the class one cycle later. It returns the class with the requester index over a backpressured response channel, and keeps saturating per-class hit counters for the rest of the design.

## Interface
- NREQ, 4, number of requesters (2..8)
- FEAT_W, 8, feature vector width
- CLS_W, 2, class width; counters exist for all 2^CLS_W classes
- CNT_W, 16, per-class counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low (fixed by decision)
- req_valid  in  NREQ  request valid, bit i for requester i
- req_feat  in  NREQ*FEAT_W  feature vectors, requester i in bits [i*FEAT_W +: FEAT_W]
- req_ready  out  NREQ  one-hot grant/accept strobe
- cls_feat  out  FEAT_W  registered feature vector driven to the shared classifier
- cls_class  in  CLS_W  combinational classifier result for cls_feat
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  clog2(NREQ)  index of the requester that owns the response
- rsp_class  out  CLS_W  captured class
- clr_stats  in  1  synchronous clear of all counters
- stat_cnt  out  (2^CLS_W)*CNT_W  per-class counters, class k in bits [k*CNT_W +: CNT_W]
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, EVAL, RESP.
- **Accept window:** the state is IDLE, or the state is RESP and rsp_ready=1.
- **Grant:** inside an accept window with any req_valid set, grant g = first set req_valid at or after ptr, scanning upward with wrap.
  - req_ready is one-hot on g, combinational, and high only in that cycle.
  - Outside accept windows req_ready = 0.
- **On accept:** feat_q <= req_feat[g]; id_q <= g; ptr <= (g+1) mod NREQ; next state EVAL.
- **IDLE:** with no request, stay in IDLE.
- **EVAL:** always lasts exactly one cycle.
  - cls_feat = feat_q and is stable for the whole cycle.
  - At the end of the cycle: rsp_class <= cls_class; rsp_id <= id_q; stat_cnt[cls_class] increments, saturating at 2^CNT_W-1; next state RESP.
- **RESP:** rsp_valid = 1, and rsp_id/rsp_class are held stable until the handshake.
  - With rsp_ready=1, the response completes. The next state is EVAL if a new request was granted in the same cycle, otherwise IDLE.
  - With rsp_ready=0, stay in RESP and grant nothing.
- ptr is unchanged when nothing is granted. A requester that deasserts req_valid before it is granted loses nothing and is simply skipped.
- cls_feat holds its last value outside EVAL. The classifier's output is ignored outside EVAL.
- **clr_stats:** zeroes every counter at the next edge. If it coincides with an EVAL increment, the clear wins and the counter ends at 0.
- **Reset (async, any state, including mid-EVAL/RESP):**
  - State goes to IDLE; ptr, feat_q, id_q, cls_feat, rsp_id, rsp_class and all stat_cnt go to 0.
  - rsp_valid, busy and req_ready go to 0.
  - The in-flight transaction is dropped with no response.

## Timing
- Accept edge at cycle T, EVAL during T+1, rsp_valid high from T+2.
- Accept-to-response latency is 2 cycles.
- Sustained throughput with rsp_ready tied high is 1 request per 2 cycles.
- The classifier has one full cycle (the EVAL cycle) from registered cls_feat to the cls_class capture edge; it must be purely combinational.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in any NREQ consecutive grants.
- rsp_valid never drops without a handshake; rsp_id and rsp_class never change while rsp_valid=1 and rsp_ready=0.

## Test plan
Bench stub classifier: cls_class = cls_feat[CLS_W-1:0].
- **Single request:** req_valid=4'b0100, req_feat[2]=8'h5A.
  - req_ready=4'b0100 for exactly 1 cycle.
  - Two cycles later: rsp_valid=1, rsp_id=2, rsp_class=2'b10.
  - stat_cnt[2]=1.
- **Full contention:** all 4 valid continuously, rsp_ready=1, feats 8'h00/8'h01/8'h02/8'h03.
  - Grants in order 0,1,2,3,0 at 2-cycle spacing.
  - rsp_class equals rsp_id each time.
  - Each counter = 1 after the first 4 responses.
- **Backpressure:** hold rsp_ready=0 for 5 cycles with another requester valid.
  - rsp_valid, rsp_id and rsp_class stay stable; req_ready stays 0.
  - When rsp_ready rises, the response completes and the waiting requester is granted in that same cycle.
- **Saturation:** CNT_W=4, 20 requests with feat 8'hFF.
  - stat_cnt[3]=15 and does not wrap.
  - clr_stats coincident with an EVAL leaves 0.
- **Reset mid-operation:** assert rst_n=0 during EVAL, then release.
  - All outputs 0, no rsp_valid, ptr=0.
  - The next request from requester 1 with requester 0 also valid grants 0 first.
- **Skip on withdrawal:** ptr=1, requester 1 drops req_valid before its grant, requester 3 is valid.
  - Grant goes to 3, and ptr becomes 0.
